// File: rtl/mem_resp.sv
// ---------------------------------------------------------------------------
// mem_resp
// Memory-side responder for the core's load/store path. Accepts one
// word-addressed request at a time, services it from an internal RAM after a
// programmable number of wait states, and returns a response through a
// valid/ready handshake. Data is carried in big-endian lane order: bits
// [31:24] are byte offset 0, enabled by mask bit [3]; bits [7:0] are byte
// offset 3, enabled by mask bit [0].
//
// Parameters
//   ADDR_W     word-address width; RAM depth is 2**ADDR_W words
//   WAIT       extra wait-state cycles per access (0..15)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active low
//   req_valid  request present
//   req_ready  responder idle and out of reset, can take a request
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data, big-endian lanes
//   req_mask   byte-lane write enables (ignored on reads)
//   rsp_valid  response present
//   rsp_ready  core accepts the response
//   rsp_rdata  read data, or 32'h0 for a write response
// ---------------------------------------------------------------------------
module mem_resp #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAITS  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Counter is loaded with WAIT-1 so that exactly WAIT cycles are spent in S_WAITS.
    localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_wait_cnt;
    logic              r_rsp_valid;
    logic [31:0]       r_rdata;

    // Latched request
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_mask;

    logic [31:0]       r_mem [0:(2**ADDR_W)-1];

    logic              w_accept;
    logic              w_do_write;

    assign req_ready  = (r_state == S_IDLE) && rst_n;
    assign w_accept   = req_valid && req_ready;
    // A write is performed only if the ACCESS cycle completes out of reset.
    assign w_do_write = rst_n && (r_state == S_ACCESS) && r_we;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rdata;

    // NOTE: combinational blocks assign every output a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next_state = (WAIT > 0) ? S_WAITS : S_ACCESS;
            S_WAITS:  if (r_wait_cnt == 4'd0) w_next_state = S_ACCESS;
            S_ACCESS: w_next_state = S_RESP;
            S_RESP:   if (rsp_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its sources regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'h0;
        end else begin
            r_state     <= w_next_state;
            r_rsp_valid <= (w_next_state == S_RESP);

            if (w_accept) begin
                r_wait_cnt <= WAIT_LOAD;
            end else if ((r_state == S_WAITS) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end

            if (r_state == S_ACCESS) begin
                r_rdata <= r_we ? 32'h0 : r_mem[r_addr];
            end
        end
    end

    // NOTE: the request latch and the RAM array carry no reset; they are
    // datapath storage that is always written before it is consumed, and a
    // reset would prevent the array from mapping onto a RAM macro.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_mask  <= req_mask;
        end
    end

    // Mask bit i enables bits [8i+7:8i]; with big-endian lanes mask[3] is offset 0.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (r_mask[i]) begin
                    r_mem[r_addr][i*8 +: 8] <= r_wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_mem_resp
// Self-checking bench for mem_resp. Three responders run side by side with
// WAIT = 1, 0 and 4 (index 0, 1, 2). A word-level reference memory, keyed by
// responder and address, predicts read data by merging written bytes per
// big-endian lane offset.
// ---------------------------------------------------------------------------
module tb_mem_resp;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [9:0]  req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_mask  [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference memory, key = responder index * 1024 + word address.
    logic [31:0] mdl [int];

    always #5 clk = ~clk;

    mem_resp #(.ADDR_W(10), .WAIT(1)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_mask(req_mask[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0])
    );

    mem_resp #(.ADDR_W(10), .WAIT(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_mask(req_mask[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1])
    );

    mem_resp #(.ADDR_W(10), .WAIT(4)) u_dut_w4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_mask(req_mask[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2])
    );

    function automatic int wait_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte offset o occupies bits [31-8o -: 8] and is enabled by mask bit 3-o.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] mk);
        logic [31:0] r;
        r = old;
        for (int o = 0; o < 4; o++) begin
            if (mk[3-o]) r[31-8*o -: 8] = wd[31-8*o -: 8];
        end
        return r;
    endfunction

    // Runs one transaction on responder k. Entered and left 1 time unit after
    // a rising edge with the responder idle. rsp_ready is held low for 'hold'
    // cycles after rsp_valid rises. Latency is counted in edges, the accept
    // edge being the first and the edge that raises rsp_valid the last.
    task automatic txn(input int k, input logic we, input logic [9:0] addr,
                       input logic [31:0] wd, input logic [3:0] mk, input int hold,
                       output logic [31:0] rd, output time t_acc);
        int          key;
        int          lat;
        logic [31:0] exp;
        key = k * 1024 + int'(addr);
        if (we) begin
            mdl[key] = merge(mdl.exists(key) ? mdl[key] : 32'h0, wd, mk);
            exp = 32'h0;
        end else begin
            exp = mdl.exists(key) ? mdl[key] : 32'h0;
        end

        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        req_mask[k]  = mk;
        req_valid[k] = 1'b1;
        rsp_ready[k] = (hold == 0);
        check($sformatf("req_ready_idle[%0d]", k), 32'(req_ready[k]), 32'd1);

        @(posedge clk);
        t_acc = $time;
        #1;
        req_valid[k] = 1'b0;
        lat = 1;
        while (rsp_valid[k] !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("latency[%0d]", k), 32'(lat), 32'(wait_of(k) + 2));
        rd = rsp_rdata[k];
        check($sformatf("rdata[%0d] addr %h", k, addr), rd, exp);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_valid[%0d]", k), 32'(rsp_valid[k]), 32'd1);
            check($sformatf("hold_rdata[%0d]", k), rsp_rdata[k], exp);
            check($sformatf("hold_req_ready[%0d]", k), 32'(req_ready[k]), 32'd0);
        end

        rsp_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("rsp_valid_drop[%0d]", k), 32'(rsp_valid[k]), 32'd0);
        check($sformatf("req_ready_back[%0d]", k), 32'(req_ready[k]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        time         t1;
        time         t2;

        // Reset state
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            req_mask[k]  = '0;
            rsp_ready[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_req_ready[%0d]", k), 32'(req_ready[k]), 32'd0);
            check($sformatf("rst_rsp_valid[%0d]", k), 32'(rsp_valid[k]), 32'd0);
            check($sformatf("rst_rsp_rdata[%0d]", k), rsp_rdata[k], 32'h0);
        end
        rst_n = 1'b1;
        #1;

        // Full write then read back (WAIT=1, latency 3)
        txn(0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF, 0, rd, t1);
        txn(0, 1'b0, 10'd5, 32'h0, 4'h0, 0, rd, t1);
        check("t1_read5", rd, 32'hDEADBEEF);

        // Partial lanes
        txn(0, 1'b1, 10'd7, 32'h11223344, 4'hF, 0, rd, t1);
        txn(0, 1'b1, 10'd7, 32'hAABBCCDD, 4'b0100, 0, rd, t1);
        txn(0, 1'b0, 10'd7, 32'h0, 4'hF, 0, rd, t1);
        check("t2_mask0100", rd, 32'h11BB3344);
        txn(0, 1'b1, 10'd7, 32'hAABBCCDD, 4'b0011, 0, rd, t1);
        txn(0, 1'b0, 10'd7, 32'h0, 4'h0, 0, rd, t1);
        check("t2_mask0011", rd, 32'h11BBCCDD);
        txn(0, 1'b1, 10'd7, 32'h55667788, 4'b0000, 0, rd, t1);
        txn(0, 1'b0, 10'd7, 32'h0, 4'h5, 0, rd, t1);
        check("t2_mask0000", rd, 32'h11BBCCDD);

        // Backpressure for 5 cycles
        txn(0, 1'b0, 10'd5, 32'h0, 4'h0, 5, rd, t1);
        check("t3_bp_read", rd, 32'hDEADBEEF);

        // Latency and back-to-back throughput for WAIT=0 and WAIT=4
        for (int k = 1; k < 3; k++) begin
            txn(k, 1'b1, 10'd3, 32'h0BADF00D + 32'(k), 4'hF, 0, rd, t1);
            txn(k, 1'b0, 10'd3, 32'h0, 4'h0, 0, rd, t1);
            txn(k, 1'b0, 10'd3, 32'h0, 4'h0, 0, rd, t2);
            check($sformatf("t4_period[%0d]", k), 32'(t2 - t1), 32'((wait_of(k) + 3) * 10));
        end

        // Reset during the wait state of a write
        txn(0, 1'b1, 10'd9, 32'h0, 4'hF, 0, rd, t1);
        req_we[0]    = 1'b1;
        req_addr[0]  = 10'd9;
        req_wdata[0] = 32'hCAFEF00D;
        req_mask[0]  = 4'hF;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rst_req_ready", 32'(req_ready[0]), 32'd0);
        check("t5_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk);
        #1;
        check("t5_rst_req_ready2", 32'(req_ready[0]), 32'd0);
        check("t5_rst_rsp_valid2", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk);
        #1;
        check("t5_rst_rsp_valid3", 32'(rsp_valid[0]), 32'd0);
        rst_n = 1'b1;
        #1;
        check("t5_release_ready", 32'(req_ready[0]), 32'd1);
        txn(0, 1'b0, 10'd9, 32'h0, 4'h0, 0, rd, t1);
        check("t5_read9", rd, 32'h0);

        // Address extremes
        txn(0, 1'b1, 10'h3FF, 32'hA5A50001, 4'hF, 0, rd, t1);
        txn(0, 1'b1, 10'h000, 32'h5A5A0002, 4'hF, 0, rd, t1);
        txn(0, 1'b0, 10'h3FF, 32'h0, 4'h0, 0, rd, t1);
        check("t6_read3ff", rd, 32'hA5A50001);
        txn(0, 1'b0, 10'h000, 32'h0, 4'h0, 0, rd, t1);
        check("t6_read000", rd, 32'h5A5A0002);

        // Randomized traffic against the reference memory
        for (int k = 0; k < 3; k++) begin
            for (int a = 16; a < 24; a++) begin
                txn(k, 1'b1, 10'(a), $urandom, 4'hF, 0, rd, t1);
            end
        end
        for (int n = 0; n < 40; n++) begin
            int k;
            k = $urandom_range(0, 2);
            txn(k, 1'($urandom_range(0, 1)), 10'(16 + $urandom_range(0, 7)), $urandom,
                4'($urandom_range(0, 15)), $urandom_range(0, 2), rd, t1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
